// File: rtl/sched_pkg.sv
// Shared constants and types for the dual-FIFO issue scheduler:
// field positions inside the 32-bit instruction, scoreboard sizing and tag type.
package sched_pkg;

  localparam int ADDR_W   = 9;
  localparam int SB_DEPTH = 4;
  localparam int TAG_W    = 2;

  localparam int DST_LSB  = 9;
  localparam int SRC_LSB  = 0;
  localparam int PRIO_BIT = 28;

  typedef logic [TAG_W-1:0] tag_t;

  typedef enum logic {
    RR_F1 = 1'b0,
    RR_F2 = 1'b1
  } rr_pref_e;

endpackage

// File: rtl/issue_scoreboard.sv
// In-flight destination scoreboard: lowest-free allocation, tagged free,
// hazard compare for both FIFO heads, sticky error on a bad free.
module issue_scoreboard #(
  parameter int ADDR_W   = sched_pkg::ADDR_W,
  parameter int SB_DEPTH = sched_pkg::SB_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_a_src,
  input  logic [ADDR_W-1:0] i_a_dst,
  input  logic [ADDR_W-1:0] i_b_src,
  input  logic [ADDR_W-1:0] i_b_dst,
  output logic              o_a_hazard,
  output logic              o_b_hazard,
  input  logic              i_alloc,
  input  logic [ADDR_W-1:0] i_alloc_dst,
  output logic [1:0]        o_alloc_tag,
  output logic              o_full,
  input  logic              i_free,
  input  logic [1:0]        i_free_tag,
  output logic              o_err
);
  import sched_pkg::*;

  logic [SB_DEPTH-1:0] r_valid;
  logic [ADDR_W-1:0]   r_dst [SB_DEPTH];
  logic                r_err;
  logic [SB_DEPTH-1:0] w_hit_a;
  logic [SB_DEPTH-1:0] w_hit_b;
  logic [SB_DEPTH-1:0] w_free_hit;
  logic                w_free_ok;
  tag_t                w_alloc_tag;

  genvar gi;
  generate
    for (gi = 0; gi < SB_DEPTH; gi++) begin : g_entry
      assign w_hit_a[gi]    = r_valid[gi] && (r_dst[gi] == i_a_src || r_dst[gi] == i_a_dst);
      assign w_hit_b[gi]    = r_valid[gi] && (r_dst[gi] == i_b_src || r_dst[gi] == i_b_dst);
      assign w_free_hit[gi] = r_valid[gi] && (i_free_tag == TAG_W'(gi));

      // Alloc only targets a free entry and free only a valid one, so they never collide.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_valid[gi] <= 1'b0;
          r_dst[gi]   <= '0;
        end else if (i_alloc && (w_alloc_tag == TAG_W'(gi))) begin
          r_valid[gi] <= 1'b1;
          r_dst[gi]   <= i_alloc_dst;
        end else if (i_free && w_free_hit[gi]) begin
          r_valid[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_comb begin
    w_alloc_tag = '0;
    for (int i = SB_DEPTH - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_alloc_tag = TAG_W'(i);
    end
  end

  assign w_free_ok = |w_free_hit;

  always_ff @(posedge clk) begin
    if (reset) r_err <= 1'b0;
    else if (i_free && !w_free_ok) r_err <= 1'b1;
  end

  assign o_a_hazard  = |w_hit_a;
  assign o_b_hazard  = |w_hit_b;
  assign o_alloc_tag = w_alloc_tag;
  assign o_full      = &r_valid;
  assign o_err       = r_err;

endmodule

// File: rtl/issue_scheduler.sv
// Two-FIFO in-order issue scheduler with round-robin arbitration onto one execution port.
// Define OVERRIDE_PRIO_EN to let instr[28] override round-robin between eligible heads.
module issue_scheduler #(
  parameter int ADDR_W   = sched_pkg::ADDR_W,
  parameter int SB_DEPTH = sched_pkg::SB_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] f1_instr,
  input  logic        f1_valid,
  output logic        f1_pop,
  input  logic [31:0] f2_instr,
  input  logic        f2_valid,
  output logic        f2_pop,
  output logic [31:0] ex_instr,
  output logic [1:0]  ex_tag,
  output logic        ex_valid,
  input  logic        ex_ready,
  input  logic        ex_done,
  input  logic [1:0]  ex_done_tag,
  output logic        sb_full,
  output logic        sb_err,
  output logic [15:0] stall_cnt
);
  import sched_pkg::*;

  logic [ADDR_W-1:0] w_f1_src, w_f1_dst, w_f2_src, w_f2_dst;
  logic              w_f1_haz, w_f2_haz, w_full, w_can_load;
  logic              w_f1_elig, w_f2_elig, w_pick_f2;
  logic              w_grant_f1, w_grant_f2, w_grant;
  tag_t              w_alloc_tag;

  logic [31:0] r_ex_instr;
  tag_t        r_ex_tag;
  logic        r_ex_valid;
  rr_pref_e    r_rr;
  logic [15:0] r_stall;

  assign w_f1_dst = f1_instr[DST_LSB +: ADDR_W];
  assign w_f1_src = f1_instr[SRC_LSB +: ADDR_W];
  assign w_f2_dst = f2_instr[DST_LSB +: ADDR_W];
  assign w_f2_src = f2_instr[SRC_LSB +: ADDR_W];

  issue_scoreboard #(.ADDR_W(ADDR_W), .SB_DEPTH(SB_DEPTH)) u_sb (
    .clk        (clk),
    .reset      (reset),
    .i_a_src    (w_f1_src),
    .i_a_dst    (w_f1_dst),
    .i_b_src    (w_f2_src),
    .i_b_dst    (w_f2_dst),
    .o_a_hazard (w_f1_haz),
    .o_b_hazard (w_f2_haz),
    .i_alloc    (w_grant),
    .i_alloc_dst(w_grant_f2 ? w_f2_dst : w_f1_dst),
    .o_alloc_tag(w_alloc_tag),
    .o_full     (w_full),
    .i_free     (ex_done),
    .i_free_tag (ex_done_tag),
    .o_err      (sb_err)
  );

  assign w_can_load = !r_ex_valid || ex_ready;
  assign w_f1_elig  = f1_valid && !w_full && w_can_load && !w_f1_haz;
  assign w_f2_elig  = f2_valid && !w_full && w_can_load && !w_f2_haz;

`ifdef OVERRIDE_PRIO_EN
  logic w_f1_prio, w_f2_prio;
  assign w_f1_prio = f1_instr[PRIO_BIT];
  assign w_f2_prio = f2_instr[PRIO_BIT];
  assign w_pick_f2 = (w_f1_prio != w_f2_prio) ? w_f2_prio : (r_rr == RR_F2);
`else
  assign w_pick_f2 = (r_rr == RR_F2);
`endif

  // Pops are combinational so the FIFO dequeues on the same edge that captures the head.
  assign w_grant_f1 = !reset && w_f1_elig && (!w_f2_elig || !w_pick_f2);
  assign w_grant_f2 = !reset && w_f2_elig && (!w_f1_elig || w_pick_f2);
  assign w_grant    = w_grant_f1 || w_grant_f2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_valid <= 1'b0;
      r_ex_instr <= '0;
      r_ex_tag   <= '0;
      r_rr       <= RR_F1;
      r_stall    <= '0;
    end else begin
      if (w_grant) begin
        r_ex_valid <= 1'b1;
        r_ex_instr <= w_grant_f2 ? f2_instr : f1_instr;
        r_ex_tag   <= w_alloc_tag;
        r_rr       <= w_grant_f1 ? RR_F2 : RR_F1;
      end else if (ex_ready) begin
        r_ex_valid <= 1'b0;
      end
      if ((f1_valid || f2_valid) && !w_grant && (r_stall != 16'hFFFF))
        r_stall <= r_stall + 16'd1;
    end
  end

  assign f1_pop    = w_grant_f1;
  assign f2_pop    = w_grant_f2;
  assign ex_instr  = r_ex_instr;
  assign ex_tag    = r_ex_tag;
  assign ex_valid  = r_ex_valid;
  assign sb_full   = w_full;
  assign stall_cnt = r_stall;

endmodule

// File: tb/tb_issue_scheduler.sv
// Self-checking bench for issue_scheduler: single-cycle vector table, directed
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_issue_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] f1_instr, f2_instr;
  logic        f1_valid, f2_valid, f1_pop, f2_pop;
  logic [31:0] ex_instr;
  logic [1:0]  ex_tag;
  logic        ex_valid, ex_ready, ex_done;
  logic [1:0]  ex_done_tag;
  logic        sb_full, sb_err;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] f1_q[$];
  logic [31:0] f2_q[$];
  logic        p1, p2;

  issue_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .f1_instr   (f1_instr),
    .f1_valid   (f1_valid),
    .f1_pop     (f1_pop),
    .f2_instr   (f2_instr),
    .f2_valid   (f2_valid),
    .f2_pop     (f2_pop),
    .ex_instr   (ex_instr),
    .ex_tag     (ex_tag),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_done    (ex_done),
    .ex_done_tag(ex_done_tag),
    .sb_full    (sb_full),
    .sb_err     (sb_err),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Bench FIFOs: head is queue front, dequeued after an edge on which the DUT popped.
  task automatic drive_heads();
    f1_valid = (f1_q.size() > 0);
    f1_instr = f1_valid ? f1_q[0] : 32'h0;
    f2_valid = (f2_q.size() > 0);
    f2_instr = f2_valid ? f2_q[0] : 32'h0;
  endtask

  task automatic half();
    @(negedge clk);
    p1 = f1_pop;
    p2 = f2_pop;
  endtask

  task automatic fin();
    @(posedge clk);
    #1;
    if (p1 && f1_q.size() > 0) void'(f1_q.pop_front());
    if (p2 && f2_q.size() > 0) void'(f2_q.pop_front());
    drive_heads();
  endtask

  task automatic do_reset();
    f1_q.delete();
    f2_q.delete();
    ex_ready = 1'b0;
    ex_done = 1'b0;
    ex_done_tag = 2'd0;
    reset = 1'b1;
    drive_heads();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    p1 = 1'b0;
    p2 = 1'b0;
  endtask

  // ---------------- behavioural reference model ----------------
  bit          m_valid [4];
  int          m_dst   [4];
  bit          m_out_v;
  logic [31:0] m_out_instr;
  int          m_out_tag;
  bit          m_next_f1;
  int          m_stall;
  bit          m_err;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 0;
      m_dst[i] = 0;
    end
    m_out_v = 0; m_out_instr = 0; m_out_tag = 0;
    m_next_f1 = 1; m_stall = 0; m_err = 0;
  endtask

  function automatic bit blocked(input logic [31:0] ins);
    int s = int'(ins[8:0]);
    int d = int'(ins[17:9]);
    for (int i = 0; i < 4; i++)
      if (m_valid[i] && (m_dst[i] == s || m_dst[i] == d)) return 1;
    return 0;
  endfunction

  task automatic model_eval(output bit g1, output bit g2);
    int n = 0;
    bit room, e1, e2, take2;
    for (int i = 0; i < 4; i++) n += int'(m_valid[i]);
    room = !m_out_v || ex_ready;
    e1 = f1_valid && (n < 4) && room && !blocked(f1_instr);
    e2 = f2_valid && (n < 4) && room && !blocked(f2_instr);
    take2 = !m_next_f1;
`ifdef OVERRIDE_PRIO_EN
    if (f1_instr[28] != f2_instr[28]) take2 = f2_instr[28];
`endif
    g1 = e1 && (!e2 || !take2);
    g2 = e2 && (!e1 || take2);
  endtask

  task automatic model_commit(input bit g1, input bit g2);
    bit          done_ok = m_valid[ex_done_tag];
    int          t = 0;
    logic [31:0] ins = g2 ? f2_instr : f1_instr;
    for (int i = 3; i >= 0; i--) if (!m_valid[i]) t = i;
    if (g1 || g2) begin
      m_out_v = 1; m_out_instr = ins; m_out_tag = t; m_next_f1 = g2;
    end else if (ex_ready) begin
      m_out_v = 0;
    end
    if (ex_done) begin
      if (done_ok) m_valid[ex_done_tag] = 0;
      else m_err = 1;
    end
    if (g1 || g2) begin
      m_valid[t] = 1;
      m_dst[t] = int'(ins[17:9]);
    end
    if ((f1_valid || f2_valid) && !(g1 || g2) && m_stall < 65535) m_stall++;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] v = $urandom;
    v[17:9] = 9'($urandom_range(0, 5));
    v[8:0]  = 9'($urandom_range(0, 5));
    return v;
  endfunction

  function automatic logic [1:0] pick_done_tag();
    int live[$];
    if ($urandom_range(0, 39) == 0) return 2'($urandom_range(0, 3));
    for (int i = 0; i < 4; i++) if (m_valid[i]) live.push_back(i);
    if (live.size() == 0) return 2'($urandom_range(0, 3));
    return 2'(live[$urandom_range(0, live.size() - 1)]);
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] f1i;
    logic        f1v;
    logic [31:0] f2i;
    logic        f2v;
    logic        e1;
    logic        e2;
    logic        ev;
    logic [31:0] ei;
  } vec_t;

  vec_t vt [8];

  logic [31:0] exp_i [4];
  logic        exp_g1 [4];
  bit          g1, g2;

  initial begin
    vt[0] = '{32'h0000_0201, 1'b1, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0201};
    vt[1] = '{32'h0,         1'b0, 32'h0000_1008, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_1008};
    vt[2] = '{32'h0000_0402, 1'b1, 32'h0000_1008, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0402};
    vt[3] = '{32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
`ifdef OVERRIDE_PRIO_EN
    vt[4] = '{32'h0000_0402, 1'b1, 32'h1000_1008, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1000_1008};
`else
    vt[4] = '{32'h0000_0402, 1'b1, 32'h1000_1008, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0402};
`endif
    vt[5] = '{32'h1000_0402, 1'b1, 32'h0000_1008, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1000_0402};
    vt[6] = '{32'hDEAD_BEEF, 1'b0, 32'h1000_1008, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1000_1008};
    vt[7] = '{32'h1000_0402, 1'b1, 32'h1000_1008, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1000_0402};

    // Reset state, including a valid head presented during reset.
    reset = 1'b1; ex_ready = 1'b1; ex_done = 1'b0; ex_done_tag = 2'd0;
    f1_instr = 32'h0000_0201; f1_valid = 1'b1; f2_instr = 32'h0; f2_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_f1_pop", 32'(f1_pop), 0);
    chk("rst_ex_valid", 32'(ex_valid), 0);
    chk("rst_ex_instr", ex_instr, 0);
    chk("rst_ex_tag", 32'(ex_tag), 0);
    chk("rst_sb_err", 32'(sb_err), 0);
    chk("rst_sb_full", 32'(sb_full), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    @(posedge clk); #1;
    reset = 1'b0; f1_valid = 1'b0;

    for (int k = 0; k < 8; k++) begin
      do_reset();
      f1_instr = vt[k].f1i; f1_valid = vt[k].f1v;
      f2_instr = vt[k].f2i; f2_valid = vt[k].f2v;
      @(negedge clk);
      chk("vec_f1_pop", 32'(f1_pop), 32'(vt[k].e1));
      chk("vec_f2_pop", 32'(f2_pop), 32'(vt[k].e2));
      @(posedge clk); #1;
      f1_valid = 1'b0; f2_valid = 1'b0;
      @(negedge clk);
      chk("vec_ex_valid", 32'(ex_valid), 32'(vt[k].ev));
      chk("vec_ex_instr", ex_instr, vt[k].ei);
      chk("vec_ex_tag", 32'(ex_tag), 0);
      $display("vec %0d f1_pop=%0b f2_pop=%0b ex_instr=0x%08h", k, vt[k].e1, vt[k].e2, ex_instr);
    end

    // Alternating grants fill the scoreboard; heads advance like a real FIFO.
    do_reset();
    f1_q = '{32'h0000_0402, 32'h0000_0C06, 32'h0000_2010};
    f2_q = '{32'h0000_1008, 32'h0000_140A, 32'h0000_2412};
    exp_i  = '{32'h0000_0402, 32'h0000_1008, 32'h0000_0C06, 32'h0000_140A};
    exp_g1 = '{1'b1, 1'b0, 1'b1, 1'b0};
    ex_ready = 1'b1;
    drive_heads();
    for (int k = 0; k < 4; k++) begin
      half();
      chk("rr_f1_pop", 32'(p1), 32'(exp_g1[k]));
      chk("rr_f2_pop", 32'(p2), 32'(!exp_g1[k]));
      if (k > 0) begin
        chk("rr_ex_instr", ex_instr, exp_i[k-1]);
        chk("rr_ex_tag", 32'(ex_tag), 32'(k - 1));
      end
      fin();
    end
    half();
    chk("rr_ex_instr", ex_instr, exp_i[3]);
    chk("rr_ex_tag", 32'(ex_tag), 3);
    chk("full_flag", 32'(sb_full), 1);
    chk("full_no_pop", 32'({p1, p2}), 0);
    fin();
    half();
    chk("full_flag_hold", 32'(sb_full), 1);
    chk("full_no_pop_hold", 32'({p1, p2}), 0);
    $display("seq fill: four grants, sb_full=%0b", sb_full);

    // RAW hazard blocks F1 until its producer completes.
    do_reset();
    f1_q = '{32'h0000_0201, 32'h0000_1C01};
    ex_ready = 1'b1;
    drive_heads();
    half();
    chk("haz_first_pop", 32'(p1), 1);
    fin();
    f2_q.push_back(32'h0000_1008);
    drive_heads();
    half();
    chk("haz_f1_blocked", 32'(p1), 0);
    chk("haz_f2_issues", 32'(p2), 1);
    fin();
    ex_done = 1'b1; ex_done_tag = 2'd0;
    half();
    chk("haz_f2_instr", ex_instr, 32'h0000_1008);
    chk("haz_f2_tag", 32'(ex_tag), 1);
    chk("haz_prefree_block", 32'(p1), 0);
    fin();
    ex_done = 1'b0;
    half();
    chk("haz_released_pop", 32'(p1), 1);
    fin();
    half();
    chk("haz_f1_instr", ex_instr, 32'h0000_1C01);
    chk("haz_f1_tag", 32'(ex_tag), 0);
    chk("haz_no_err", 32'(sb_err), 0);
    $display("seq hazard: f1 released after done, tag=%0d", ex_tag);

    // Backpressure holds the output and counts stalls.
    do_reset();
    f1_q = '{32'h0000_0201, 32'h0000_0402};
    drive_heads();
    half();
    chk("bp_first_pop", 32'(p1), 1);
    fin();
    for (int k = 0; k < 5; k++) begin
      half();
      chk("bp_no_pop", 32'(p1), 0);
      chk("bp_instr_hold", ex_instr, 32'h0000_0201);
      chk("bp_valid_hold", 32'(ex_valid), 1);
      fin();
    end
    half();
    chk("bp_stall_cnt", 32'(stall_cnt), 5);
    $display("seq backpressure: stall_cnt=%0d", stall_cnt);

    // Freeing a non-valid entry raises a sticky error.
    do_reset();
    ex_done = 1'b1; ex_done_tag = 2'd3;
    half();
    fin();
    ex_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      half();
      chk("err_sticky", 32'(sb_err), 1);
      fin();
    end
    do_reset();
    half();
    chk("err_cleared", 32'(sb_err), 0);
    $display("seq bad free: sb_err sticky until reset");

    // Reset mid-flight discards the entry and ignores ex_done in the reset cycle.
    do_reset();
    f1_q = '{32'h0000_0201};
    drive_heads();
    half();
    fin();
    reset = 1'b1; ex_done = 1'b1; ex_done_tag = 2'd0;
    @(posedge clk); #1;
    reset = 1'b0; ex_done = 1'b0;
    f1_q.delete(); drive_heads(); p1 = 1'b0; p2 = 1'b0;
    half();
    chk("midrst_ex_valid", 32'(ex_valid), 0);
    chk("midrst_sb_err", 32'(sb_err), 0);
    fin();
    ex_done = 1'b1; ex_done_tag = 2'd0;
    half();
    fin();
    ex_done = 1'b0;
    half();
    chk("midrst_entry_gone", 32'(sb_err), 1);
    $display("seq mid reset: in-flight state discarded");

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (f1_q.size() < 3 && $urandom_range(0, 1) == 1) f1_q.push_back(rand_instr());
      if (f2_q.size() < 3 && $urandom_range(0, 1) == 1) f2_q.push_back(rand_instr());
      ex_ready = ($urandom_range(0, 3) != 0);
      ex_done = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        ex_done = 1'b1;
        ex_done_tag = pick_done_tag();
      end
      drive_heads();
      half();
      model_eval(g1, g2);
      chk("rnd_f1_pop", 32'(p1), 32'(g1));
      chk("rnd_f2_pop", 32'(p2), 32'(g2));
      chk("rnd_ex_valid", 32'(ex_valid), 32'(m_out_v));
      if (m_out_v) begin
        chk("rnd_ex_instr", ex_instr, m_out_instr);
        chk("rnd_ex_tag", 32'(ex_tag), 32'(m_out_tag));
      end
      chk("rnd_sb_full", 32'(sb_full), 32'(m_valid[0] && m_valid[1] && m_valid[2] && m_valid[3]));
      chk("rnd_sb_err", 32'(sb_err), 32'(m_err));
      chk("rnd_stall", 32'(stall_cnt), 32'(m_stall));
      model_commit(g1, g2);
      fin();
    end
    $display("random phase: 600 cycles, stall_cnt=%0d", stall_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/issue_scheduler.md
ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, giving the source/destination address field width.
REQ-002 SHALL have parameter SB_DEPTH, default 4, giving the number of in-flight scoreboard entries; tag width = 2.
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-004 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports: f1_instr  in  32  FIFO1 head; f1_valid  in  1  head valid; f1_pop  out  1  dequeue pulse.
REQ-006 SHALL have ports: f2_instr  in  32; f2_valid  in  1; f2_pop  out  1; same meanings for FIFO2.
REQ-007 SHALL have ports: ex_instr  out  32; ex_tag  out  2; ex_valid  out  1; ex_ready  in  1; shared execution port.
REQ-008 SHALL have ports: ex_done  in  1; ex_done_tag  in  2; completion of the in-flight instruction with that tag.
REQ-009 SHALL have ports: sb_full  out  1; sb_err  out  1 sticky; stall_cnt  out  16.

Function
REQ-010 SHALL decode dst = instr[17:9], src = instr[8:0], prio = instr[28].
REQ-011 SHALL treat a head as eligible when valid, a scoreboard entry is free, the output register can load, and no valid scoreboard entry's dst equals the head's src or dst.
REQ-012 SHALL load the output register when it is empty, or holds ex_valid with ex_ready=1 in the same cycle.
REQ-013 SHALL arbitrate round-robin: both eligible -> grant the FIFO not granted last; one eligible -> grant it.
REQ-014 SHALL, on grant, pulse the granted fX_pop for exactly one cycle and capture its instr into ex_instr; ex_valid=1 the next cycle (latency 1).
REQ-015 SHALL hold ex_instr, ex_tag and ex_valid stable while ex_valid=1 and ex_ready=0.
REQ-016 SHALL allocate the lowest free scoreboard index at capture, record dst, and drive it as ex_tag.
REQ-017 SHALL free entry ex_done_tag on ex_done; freeing and allocating in the same cycle SHALL use the pre-free state for both hazard checking and allocation.
REQ-018 SHALL set sb_err when ex_done names a non-valid entry, and SHALL leave the scoreboard unchanged.
REQ-019 SHALL drive sb_full=1 when all SB_DEPTH entries are valid.
REQ-020 SHALL increment stall_cnt each cycle in which f1_valid or f2_valid is 1 and no pop occurs, saturating at 16'hFFFF.

Reset
REQ-021 SHALL, on reset, clear all of the following: all scoreboard entries, ex_valid, ex_instr, ex_tag, f1_pop, f2_pop, sb_err and stall_cnt, and set round-robin preference to FIFO1.
REQ-022 SHALL, on reset mid-operation, discard in-flight state; ex_done in the reset cycle is ignored.

Configuration
REQ-023 With OVERRIDE_PRIO_EN defined, an eligible head with prio=1 SHALL beat an eligible head with prio=0 regardless of round-robin; equal prio falls back to round-robin.
REQ-024 Without OVERRIDE_PRIO_EN, instr[28] SHALL be ignored by arbitration.

Structure
REQ-025 Package sched_pkg SHALL hold ADDR_W, SB_DEPTH, the tag type and the dst/src/prio field bit positions.
REQ-026 Scoreboard storage, allocation, free and hazard compare SHALL reside in sub-module issue_scoreboard.

Verification
REQ-027 The bench SHALL cover: reset, f1 = 0x0000_0201, ex_ready=1 -> one f1_pop; next cycle ex_valid=1, ex_instr=0x0000_0201, ex_tag=0.
REQ-028 The bench SHALL cover: f1 = 0x0000_0402 and f2 = 0x0000_1008, both held valid, ex_ready=1 -> grants F1, F2, F1, F2 with tags 0, 1, 2, 3, then sb_full=1 and no pops.
REQ-029 The bench SHALL cover: tag0 in flight with dst=1, f1 = 0x0000_1C01 (src=1) -> f1 is not popped; f2 = 0x0000_1008 issues meanwhile; ex_done with tag 0 -> f1 pops the next cycle.
REQ-030 The bench SHALL cover: ex_ready=0 with ex_valid=1 for 5 cycles -> ex_instr is stable, no pops, stall_cnt=5.
REQ-031 The bench SHALL cover: ex_done with tag 3 while entry 3 is free -> sb_err=1, which stays set until reset.
REQ-032 The bench SHALL cover: round-robin favours F1, f1 = 0x0000_0402, f2 = 0x1000_1008 -> F2 is granted with OVERRIDE_PRIO_EN, F1 is granted without it.
